// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the TX frame arbiter and its round-robin picker.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] ABORT_BYTE = 8'h00;

    // Width of a source index; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_frame_arbiter_if.sv
// Stream bundle between N byte sources, the arbiter and the MAC TX port.
interface tx_frame_arbiter_if #(
    parameter int N_SRC = 2
);
    // Every stream here is AXI-Stream: a beat moves on a cycle where tvalid and tready
    // are both high; tvalid never waits on tready, and tready may depend on tvalid.
    logic [N_SRC-1:0]   s_tvalid;
    logic [N_SRC-1:0]   s_tlast;
    logic [N_SRC*8-1:0] s_tdata;
    logic [N_SRC-1:0]   s_tready;
    logic               m_tvalid;
    logic               m_tlast;
    logic [7:0]         m_tdata;
    logic               m_tready;

    modport master (
        input  s_tvalid, s_tlast, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tlast, m_tdata
    );

    modport slave (
        output s_tvalid, s_tlast, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tlast, m_tdata
    );
endinterface

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N_SRC.
module rr_select
    import tx_arb_pkg::*;
#(
    parameter  int N_SRC = 2,
    localparam int GW    = grant_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [GW-1:0]    last,
    output logic [GW-1:0]    idx,
    output logic             valid
);
    logic [GW:0]   w_sum;
    logic [GW-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            w_sum = {1'b0, last} + (GW + 1)'(k);
            if (w_sum >= (GW + 1)'(N_SRC)) begin
                w_sum = w_sum - (GW + 1)'(N_SRC);
            end
            w_cand = w_sum[GW-1:0];
            if (req[w_cand]) begin
                idx   = w_cand;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one 8-bit AXI-Stream TX port, with a post-frame idle gap.
// Define TXARB_WATCHDOG_EN to abort and drain a frame whose source stalls for STALL_LIMIT cycles.
module tx_frame_arbiter
    import tx_arb_pkg::*;
#(
    parameter  int N_SRC       = 2,
    parameter  int GAP_CYCLES  = 12,
    parameter  int STALL_LIMIT = 1024,
    localparam int GW          = grant_w(N_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    tx_frame_arbiter_if.master bus,
    output logic [GW-1:0]      grant,
    output logic               busy,
    output logic [15:0]        frames_sent,
    output state_t             o_dbg_state
);
    localparam int     GCW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam state_t POST_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t         r_state;
    state_t         w_state_nx;
    logic [GW-1:0]  r_grant;
    logic [GW-1:0]  r_last_grant;
    logic [GW-1:0]  w_pick_idx;
    logic           w_pick_valid;
    logic           w_sel_valid;
    logic           w_sel_last;
    logic [7:0]     w_sel_data;
    logic           w_frame_done;
    logic           w_gap_load;
    logic [GCW-1:0] r_gap_cnt;
    logic [15:0]    r_frames;

    rr_select #(.N_SRC(N_SRC)) u_rr_select (
        .req   (bus.s_tvalid),
        .last  (r_last_grant),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    assign w_sel_valid = bus.s_tvalid[r_grant];
    assign w_sel_last  = bus.s_tlast[r_grant];
    assign w_sel_data  = bus.s_tdata[{r_grant, 3'b000} +: 8];

`ifdef TXARB_WATCHDOG_EN
    localparam int SCW = $clog2(STALL_LIMIT + 1);

    logic [SCW-1:0] r_stall_cnt;
    logic           w_abort;

    // The counter freezes at the limit so the abort beat stays up until the MAC takes it.
    assign w_abort = (r_stall_cnt == SCW'(STALL_LIMIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_state != XFER) begin
            r_stall_cnt <= '0;
        end else if (!w_abort) begin
            r_stall_cnt <= w_sel_valid ? '0 : r_stall_cnt + 1'b1;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (STALL_LIMIT > 0) ^ (|ABORT_BYTE);
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_frame_done = 1'b0;
        bus.m_tvalid = 1'b0;
        bus.m_tlast  = 1'b0;
        bus.m_tdata  = '0;
        bus.s_tready = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nx = XFER;
                end
            end
            XFER: begin
`ifdef TXARB_WATCHDOG_EN
                if (w_abort) begin
                    bus.m_tvalid = 1'b1;
                    bus.m_tlast  = 1'b1;
                    bus.m_tdata  = ABORT_BYTE;
                    if (bus.m_tready) begin
                        w_state_nx = DRAIN;
                    end
                end else begin
`else
                begin
`endif
                    bus.m_tvalid          = w_sel_valid;
                    bus.m_tlast           = w_sel_last;
                    bus.m_tdata           = w_sel_data;
                    bus.s_tready[r_grant] = bus.m_tready;
                    if (w_sel_valid && bus.m_tready && w_sel_last) begin
                        w_frame_done = 1'b1;
                        w_state_nx   = POST_FRAME;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nx = IDLE;
                end
            end
`ifdef TXARB_WATCHDOG_EN
            DRAIN: begin
                bus.s_tready[r_grant] = 1'b1;
                if (w_sel_valid && w_sel_last) begin
                    w_state_nx = POST_FRAME;
                end
            end
`endif
            default: w_state_nx = IDLE;
        endcase
    end

    assign w_gap_load = (w_state_nx == GAP) && (r_state != GAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(N_SRC - 1);
            r_gap_cnt    <= '0;
            r_frames     <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == IDLE && w_pick_valid) begin
                r_grant      <= w_pick_idx;
                r_last_grant <= w_pick_idx;
            end
            if (w_frame_done) begin
                r_frames <= r_frames + 16'd1;
            end
            if (w_gap_load) begin
                r_gap_cnt <= GCW'(GAP_CYCLES - 1);
            end else if (r_state == GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    assign grant       = r_grant;
    assign busy        = (r_state != IDLE);
    assign frames_sent = r_frames;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: rotation, gap, backpressure, hold-off, reset and (optionally) watchdog.
module tb_tx_frame_arbiter;
  import tx_arb_pkg::*;

  localparam int N_SRC = 2;
  localparam int GAP   = 12;
  localparam int STALL = 16;
  localparam int W     = 10;  // {grant, tlast, tdata}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:0]  grant;
  logic        busy;
  logic [15:0] frames_sent;
  state_t      dbg_state;

  tx_frame_arbiter_if #(.N_SRC(N_SRC)) bus ();

  tx_frame_arbiter #(
    .N_SRC(N_SRC), .GAP_CYCLES(GAP), .STALL_LIMIT(STALL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.master), .grant(grant),
    .busy(busy), .frames_sent(frames_sent), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]   src0_q[$];
  logic [8:0]   src1_q[$];
  logic [W-1:0] exp_q[$];
  int           hs_gap_q[$];
  logic [1:0]   src_en = 2'b11;
  int           src0_cnt = 0;
  int           src0_cut = -1;
  bit           ready_rand = 1'b0;
  bit           ready_chk = 1'b1;
  int           rdy_viol = 0;
  int           lowrun = 0;
  bit           bmon = 1'b0;
  int           brun = 0;
  int           busy_len = -1;
  int           exp_frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic add_src(input int src, input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      if (src == 0) src0_q.push_back({(i == len - 1), base + 8'(i)});
      else          src1_q.push_back({(i == len - 1), base + 8'(i)});
    end
  endtask

  task automatic add_exp(input int src, input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({1'(src), (i == len - 1), base + 8'(i)});
  endtask

  // One clock: drive, settle, observe both handshake sides, advance to posedge+1.
  task automatic step();
    bus.s_tvalid[0] = src_en[0] && (src0_q.size() > 0);
    {bus.s_tlast[0], bus.s_tdata[7:0]} = (src0_q.size() > 0) ? src0_q[0] : 9'h0;
    bus.s_tvalid[1] = src_en[1] && (src1_q.size() > 0);
    {bus.s_tlast[1], bus.s_tdata[15:8]} = (src1_q.size() > 0) ? src1_q[0] : 9'h0;
    bus.m_tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #2;
    if (ready_chk) begin
      if (dbg_state == XFER) begin
        if (bus.s_tready[grant] !== bus.m_tready || bus.s_tready[grant ^ 1'b1] !== 1'b0) rdy_viol++;
      end else if (bus.s_tready !== 2'b00) begin
        rdy_viol++;
      end
    end
    if (bmon) begin
      if (busy) brun++;
      else begin busy_len = brun; bmon = 1'b0; end
    end
    if (bus.m_tvalid && bus.m_tready) begin
      hs_gap_q.push_back(lowrun);
      lowrun = 0;
      chk("beat", {22'd0, grant, bus.m_tlast, bus.m_tdata},
          (exp_q.size() > 0) ? {22'd0, exp_q.pop_front()} : 32'hDEAD_0000);
      if (bus.m_tlast) begin bmon = 1'b1; brun = 0; end
    end else if (!bus.m_tvalid) begin
      lowrun++;
    end
    if (bus.s_tvalid[0] && bus.s_tready[0]) begin
      void'(src0_q.pop_front());
      src0_cnt++;
      if (src0_cnt == src0_cut) src_en[0] = 1'b0;
    end
    if (bus.s_tvalid[1] && bus.s_tready[1]) void'(src1_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < limit) begin
      step();
      n++;
    end
    chk(tag, exp_q.size() + 32'(busy), 32'd0);
    run_cycles(2);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_m_tvalid"}, 32'(bus.m_tvalid), 32'd0);
    chk({pfx, "_m_tlast"}, 32'(bus.m_tlast), 32'd0);
    chk({pfx, "_m_tdata"}, 32'(bus.m_tdata), 32'd0);
    chk({pfx, "_s_tready"}, 32'(bus.s_tready), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_grant"}, 32'(grant), 32'd0);
    chk({pfx, "_frames"}, 32'(frames_sent), 32'd0);
    chk({pfx, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  string hello = "HE11O WORLD";

  initial begin
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.s_tdata  = '0;
    bus.m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;

    // Two sources always requesting, 4-byte frames: rotation 0,1,0,1 from reset.
    add_src(0, 8'h10, 4); add_src(1, 8'h20, 4); add_src(0, 8'h30, 4); add_src(1, 8'h40, 4);
    add_exp(0, 8'h10, 4); add_exp(1, 8'h20, 4); add_exp(0, 8'h30, 4); add_exp(1, 8'h40, 4);
    exp_frames += 4;
    drain("rot_drain", 400);
    chk("rot_first_latency", hs_gap_q[0], 32'd1);
    chk("rot_gap_then_arb", hs_gap_q[4], 32'(GAP + 1));
    chk("rot_frames", 32'(frames_sent), 32'(exp_frames));

    // Single source 0 sends the 11-byte message; busy spans exactly the gap afterwards.
    for (int i = 0; i < hello.len(); i++) begin
      src0_q.push_back({(i == hello.len() - 1), hello[i]});
      exp_q.push_back({1'b0, (i == hello.len() - 1), hello[i]});
    end
    exp_frames += 1;
    drain("hello_drain", 200);
    chk("hello_gap_len", busy_len, 32'(GAP));
    chk("hello_frames", 32'(frames_sent), 32'(exp_frames));

    // 64-byte frame under random MAC backpressure.
    ready_rand = 1'b1;
    for (int i = 0; i < 64; i++) begin
      src0_q.push_back({(i == 63), 8'(i * 3 + 7)});
      exp_q.push_back({1'b0, (i == 63), 8'(i * 3 + 7)});
    end
    exp_frames += 1;
    drain("bp_drain", 2000);
    ready_rand = 1'b0;
    chk("bp_frames", 32'(frames_sent), 32'(exp_frames));

    // Source 1 arrives mid-frame and must wait for tlast plus the gap.
    hs_gap_q.delete();
    add_src(0, 8'h70, 8); add_exp(0, 8'h70, 8);
    run_cycles(3);
    add_src(1, 8'h80, 4); add_exp(1, 8'h80, 4);
    exp_frames += 2;
    drain("hold_drain", 400);
    chk("hold_gap_then_arb", hs_gap_q[8], 32'(GAP + 1));
    chk("hold_frames", 32'(frames_sent), 32'(exp_frames));
    chk("ready_rules", rdy_viol, 32'd0);

    // Reset asserted while byte 5 of a frame is presented.
    add_src(0, 8'h90, 10); add_exp(0, 8'h90, 10);
    begin
      int n = 0;
      while (exp_q.size() > 6 && n < 100) begin step(); n++; end
    end
    chk("mid_reached_byte5", exp_q.size(), 32'd6);
    reset = 1'b1;
    #2;
    check_reset_outputs("midrst");
    src0_q.delete(); src1_q.delete(); exp_q.delete(); hs_gap_q.delete();
    exp_frames = 0; bmon = 1'b0; lowrun = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    add_src(0, 8'hA0, 3); add_src(1, 8'hB0, 3);
    add_exp(0, 8'hA0, 3); add_exp(1, 8'hB0, 3);
    exp_frames += 2;
    drain("post_rst_drain", 200);
    chk("post_rst_latency", hs_gap_q[0], 32'd1);
    chk("post_rst_frames", 32'(frames_sent), 32'(exp_frames));

`ifdef TXARB_WATCHDOG_EN
    // Source 0 stalls after 3 bytes: abort beat, drain of the rest, then source 1.
    ready_chk = 1'b0;
    hs_gap_q.delete();
    src0_cnt = 0; src0_cut = 3;
    add_src(0, 8'h50, 8); add_src(1, 8'h60, 3);
    add_exp(0, 8'h50, 3);
    exp_q.push_back({1'b0, 1'b1, ABORT_BYTE});
    add_exp(1, 8'h60, 3);
    exp_frames += 1;
    begin
      int n = 0;
      while (exp_q.size() > 3 && n < 400) begin step(); n++; end
    end
    chk("wd_abort_seen", exp_q.size(), 32'd3);
    src_en[0] = 1'b1; src0_cut = -1;
    drain("wd_drain", 400);
    chk("wd_stall_cycles", hs_gap_q[3], 32'(STALL));
    chk("wd_src0_drained", src0_q.size(), 32'd0);
    chk("wd_frames", 32'(frames_sent), 32'(exp_frames));
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
